// File: rtl/dac_mon_pkg.sv
// rtl/dac_mon_pkg.sv - shared constants, state type and frame-length helper for the DAC link monitor
package dac_mon_pkg;

  localparam logic [3:0] CMD_WR_UPD       = 4'h3;
  localparam logic [3:0] CMD_NOP          = 4'h7;
  localparam int         CHAIN_WORD_BITS  = 32;
  localparam int         QUAD_WORD_BITS   = 24;
  localparam int         CHAIN_FRAME_BITS = 128;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    CHECK
  } mon_state_t;

  // A chain frame is well formed only when it carries 1..4 complete 32-bit words.
  function automatic logic chain_len_ok(input logic [7:0] n);
    return (n != 8'd0) && ((n % 8'(CHAIN_WORD_BITS)) == 8'd0) &&
           (n <= 8'(CHAIN_FRAME_BITS));
  endfunction

endpackage

// File: rtl/dac_mon_edge_sync.sv
// rtl/dac_mon_edge_sync.sv - optional input synchronizer plus sclk-rise and csel-fall/rise strobes
module dac_mon_edge_sync #(
  parameter int SYNC_STAGES = 0
) (
  input  logic clkin,
  input  logic reset,
  input  logic sclk,
  input  logic csel,
  input  logic mosi,
  output logic mosi_s,
  output logic sclk_rise,
  output logic csel_fall,
  output logic csel_rise
);

  logic [2:0] raw;
  logic [2:0] synced;
  logic       sclk_d;
  logic       csel_d;

  assign raw = {sclk, csel, mosi};

  generate
    if (SYNC_STAGES == 0) begin : g_direct
      assign synced = raw;
    end else begin : g_sync
      logic [SYNC_STAGES-1:0][2:0] stage;

      // Idle link level (sclk low, csel high) so reset never fakes an edge.
      always_ff @(posedge clkin) begin
        if (reset) begin
          stage <= {SYNC_STAGES{3'b010}};
        end else begin
          stage[0] <= raw;
          for (int i = 1; i < SYNC_STAGES; i++) begin
            stage[i] <= stage[i-1];
          end
        end
      end

      assign synced = stage[SYNC_STAGES-1];
    end
  endgenerate

  always_ff @(posedge clkin) begin
    if (reset) begin
      sclk_d <= 1'b0;
      csel_d <= 1'b1;
    end else begin
      sclk_d <= synced[2];
      csel_d <= synced[1];
    end
  end

  assign mosi_s    = synced[0];
  assign sclk_rise = synced[2] & ~sclk_d;
  assign csel_fall = ~synced[1] & csel_d;
  assign csel_rise = synced[1] & ~csel_d;

endmodule

// File: rtl/dac_spi_monitor.sv
// rtl/dac_spi_monitor.sv - DAC serial link decoder with per-channel shadow; DAC_MON_COUNTERS_EN adds frame/error counters
module dac_spi_monitor
  import dac_mon_pkg::*;
#(
  parameter int SYNC_STAGES = 0,
  parameter int NUM_CHAN    = 4
) (
  input  logic                    clkin,
  input  logic                    reset,
  input  logic                    sclk,
  input  logic                    csel,
  input  logic                    mosi,
  input  logic                    isQuadDac,
  output logic                    word_valid,
  output logic [1:0]              word_chan,
  output logic [3:0]              word_cmd,
  output logic [15:0]             word_data,
  output logic [16*NUM_CHAN-1:0]  ch_data,
  output logic                    busy,
  output logic                    frame_err
`ifdef DAC_MON_COUNTERS_EN
  ,
  output logic [15:0]             frame_count,
  output logic [15:0]             err_count
`endif
);

  mon_state_t  state;
  mon_state_t  state_nxt;
  logic        mosi_s;
  logic        sclk_rise;
  logic        csel_fall;
  logic        csel_rise;

  logic [26:0] shreg;
  logic [7:0]  bitcnt;
  logic        quad_mode;

  logic        start;
  logic        shift_bit;
  logic        frame_end;
  logic        len_ok;
  logic        chain_word;
  logic        quad_word;
  logic        valid_nxt;
  logic        err_nxt;
  logic [27:0] word_cur;
  logic [7:0]  bitcnt_nxt;
  logic [1:0]  chan_nxt;
  logic [3:0]  cmd_nxt;
  logic [15:0] data_nxt;

  dac_mon_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_edge_sync (
    .clkin     (clkin),
    .reset     (reset),
    .sclk      (sclk),
    .csel      (csel),
    .mosi      (mosi),
    .mosi_s    (mosi_s),
    .sclk_rise (sclk_rise),
    .csel_fall (csel_fall),
    .csel_rise (csel_rise)
  );

  always_ff @(posedge clkin) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (csel_fall) state_nxt = SHIFT;
      SHIFT:   if (csel_rise) state_nxt = CHECK;
      CHECK:   state_nxt = csel_fall ? SHIFT : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // word_cur is the frame as it stands after this cycle's bit (if any) is taken,
  // so a bit arriving together with the csel rise is counted before framing is judged.
  always_comb begin
    start      = (state != SHIFT) && (state_nxt == SHIFT);
    shift_bit  = (state == SHIFT) && sclk_rise;
    frame_end  = (state == SHIFT) && csel_rise;
    word_cur   = shift_bit ? {shreg, mosi_s} : {1'b0, shreg};
    bitcnt_nxt = (shift_bit && (bitcnt != 8'hFF)) ? bitcnt + 8'd1 : bitcnt;
    len_ok     = quad_mode ? (bitcnt_nxt == 8'(QUAD_WORD_BITS)) : chain_len_ok(bitcnt_nxt);
    chain_word = shift_bit && !quad_mode && chain_len_ok(bitcnt_nxt);
    quad_word  = frame_end && quad_mode && len_ok;
    valid_nxt  = chain_word || quad_word;
    err_nxt    = frame_end && !len_ok;
    cmd_nxt    = quad_mode ? word_cur[23:20] : word_cur[27:24];
    chan_nxt   = quad_mode ? word_cur[17:16] : bitcnt[6:5];
    data_nxt   = word_cur[15:0];
  end

  assign busy = (state == SHIFT);

  always_ff @(posedge clkin) begin
    if (reset) begin
      shreg      <= '0;
      bitcnt     <= '0;
      quad_mode  <= 1'b0;
      word_valid <= 1'b0;
      word_chan  <= '0;
      word_cmd   <= '0;
      word_data  <= '0;
      frame_err  <= 1'b0;
      ch_data    <= '0;
    end else begin
      word_valid <= valid_nxt;
      frame_err  <= err_nxt;
      if (valid_nxt) begin
        word_chan <= chan_nxt;
        word_cmd  <= cmd_nxt;
        word_data <= data_nxt;
      end
      if (valid_nxt && (cmd_nxt == CMD_WR_UPD)) begin
        ch_data[{chan_nxt, 4'b0000} +: 16] <= data_nxt;
      end
      if (start) begin
        shreg     <= '0;
        bitcnt    <= '0;
        quad_mode <= isQuadDac;
      end else if (shift_bit) begin
        shreg  <= word_cur[26:0];
        bitcnt <= bitcnt_nxt;
      end
    end
  end

`ifdef DAC_MON_COUNTERS_EN
  always_ff @(posedge clkin) begin
    if (reset) begin
      frame_count <= '0;
      err_count   <= '0;
    end else begin
      if (frame_end && len_ok && (frame_count != 16'hFFFF)) frame_count <= frame_count + 16'd1;
      if (err_nxt && (err_count != 16'hFFFF)) err_count <= err_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dac_spi_monitor.sv
// tb/tb_dac_spi_monitor.sv - directed self-checking bench driving a direct and a 2-stage-synchronized monitor
module tb_dac_spi_monitor;
  import dac_mon_pkg::*;

  logic        clk;
  logic        reset;
  logic        sclk;
  logic        csel;
  logic        mosi;
  logic        isq;

  logic        wv0, wv1, busy0, busy1, fe0, fe1;
  logic [1:0]  wc0, wc1;
  logic [3:0]  wcmd0, wcmd1;
  logic [15:0] wd0, wd1;
  logic [63:0] chd0, chd1;
`ifdef DAC_MON_COUNTERS_EN
  logic [15:0] fc0, ec0, fc1, ec1;
`endif

  int checks   = 0;
  int failures = 0;
  int err0     = 0;
  int err1     = 0;
  int overlap  = 0;
  logic [21:0] q0[$];
  logic [21:0] q1[$];

  dac_spi_monitor #(.SYNC_STAGES(0)) u_dut0 (
    .clkin(clk), .reset(reset), .sclk(sclk), .csel(csel), .mosi(mosi), .isQuadDac(isq),
    .word_valid(wv0), .word_chan(wc0), .word_cmd(wcmd0), .word_data(wd0),
    .ch_data(chd0), .busy(busy0), .frame_err(fe0)
`ifdef DAC_MON_COUNTERS_EN
    , .frame_count(fc0), .err_count(ec0)
`endif
  );

  dac_spi_monitor #(.SYNC_STAGES(2)) u_dut1 (
    .clkin(clk), .reset(reset), .sclk(sclk), .csel(csel), .mosi(mosi), .isQuadDac(isq),
    .word_valid(wv1), .word_chan(wc1), .word_cmd(wcmd1), .word_data(wd1),
    .ch_data(chd1), .busy(busy1), .frame_err(fe1)
`ifdef DAC_MON_COUNTERS_EN
    , .frame_count(fc1), .err_count(ec1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wv0) q0.push_back({wc0, wcmd0, wd0});
    if (wv1) q1.push_back({wc1, wcmd1, wd1});
    if (fe0) err0++;
    if (fe1) err1++;
    if ((wv0 && fe0) || (wv1 && fe1)) overlap++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear();
    q0.delete();
    q1.delete();
    err0 = 0;
    err1 = 0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    csel  = 1'b1;
    sclk  = 1'b0;
    idle(4);
    reset = 1'b0;
    idle(3);
  endtask

  // bits[nbits-1] goes out first; mosi changes while sclk is low.
  task automatic send_frame(input logic [159:0] bits, input int nbits, input int half,
                            input int cs_dly, input bit join_last, input bit flip, input bit hold);
    #(cs_dly) csel = 1'b0;
    repeat (half) @(negedge clk);
    for (int i = nbits - 1; i >= 0; i--) begin
      sclk = 1'b0;
      mosi = bits[i];
      repeat (half) @(negedge clk);
      if (flip && i == nbits / 2) isq = ~isq;
      sclk = 1'b1;
      if (join_last && !hold && i == 0) csel = 1'b1;
      repeat (half) @(negedge clk);
    end
    sclk = 1'b0;
    if (!join_last && !hold) begin
      repeat (half) @(negedge clk);
      #(cs_dly) csel = 1'b1;
    end
  endtask

  initial begin
    reset = 1'b1;
    sclk  = 1'b0;
    csel  = 1'b1;
    mosi  = 1'b0;
    isq   = 1'b0;
    idle(4);
    check("rst_word_valid", wv0, 1'b0);
    check("rst_busy", busy0, 1'b0);
    check("rst_frame_err", fe0, 1'b0);
    check("rst_ch_data", chd0, 64'h0);
    check("rst_word_data", wd0, 16'h0);
    reset = 1'b0;
    idle(3);

    // Chain frame at full sclk rate, last bit together with csel rise, mode flipped mid-frame.
    clear();
    send_frame({32'h03001234, 32'h03005678, 32'h07009ABC, 32'h0300FFFF}, 128, 1, 2, 1'b1, 1'b1, 1'b0);
    isq = 1'b0;
    idle(8);
    check("chain_count", q0.size(), 4);
    check("chain_w0", q0[0], {2'd0, CMD_WR_UPD, 16'h1234});
    check("chain_w1", q0[1], {2'd1, CMD_WR_UPD, 16'h5678});
    check("chain_w2", q0[2], {2'd2, CMD_NOP, 16'h9ABC});
    check("chain_w3", q0[3], {2'd3, CMD_WR_UPD, 16'hFFFF});
    check("chain_shadow", chd0, 64'hFFFF_0000_5678_1234);
    check("chain_err", err0, 0);
    check("chain_sync_count", q1.size(), 4);
    check("chain_sync_shadow", chd1, 64'hFFFF_0000_5678_1234);

    // Quad mode: back-to-back frames with a single idle csel cycle between the first two.
    isq = 1'b1;
    clear();
    send_frame(160'h30ABCD, 24, 1, 2, 1'b1, 1'b0, 1'b0);
    send_frame(160'h31BEEF, 24, 1, 2, 1'b0, 1'b0, 1'b0);
    idle(4);
    send_frame(160'h707777, 24, 1, 2, 1'b0, 1'b0, 1'b0);
    idle(8);
    check("quad_count", q0.size(), 3);
    check("quad_w0", q0[0], {2'd0, 4'h3, 16'hABCD});
    check("quad_w1", q0[1], {2'd1, 4'h3, 16'hBEEF});
    check("quad_w2", q0[2], {2'd0, 4'h7, 16'h7777});
    check("quad_shadow", chd0, 64'hFFFF_0000_BEEF_ABCD);
    check("quad_err", err0, 0);

    // Chain frame aborted after 40 bits.
    isq = 1'b0;
    clear();
    send_frame({32'h03002222, 8'hA5}, 40, 1, 2, 1'b0, 1'b0, 1'b0);
    idle(8);
    check("abort_count", q0.size(), 1);
    check("abort_w0", q0[0], {2'd0, 4'h3, 16'h2222});
    check("abort_err", err0, 1);
    check("abort_shadow", chd0, 64'hFFFF_0000_BEEF_2222);

    // Chain frame running 8 bits past 128.
    clear();
    send_frame({32'h03000011, 32'h03000022, 32'h03000033, 32'h03000044, 8'hFF}, 136, 1, 2,
               1'b0, 1'b0, 1'b0);
    idle(8);
    check("over_count", q0.size(), 4);
    check("over_err", err0, 1);
    check("over_shadow", chd0, 64'h0044_0033_0022_0011);

    // Reset in the middle of a frame, then a clean frame.
    clear();
    send_frame(160'h1FFFF, 17, 1, 2, 1'b0, 1'b0, 1'b1);
    idle(3);
    check("mid_busy", busy0, 1'b1);
    reset = 1'b1;
    csel  = 1'b1;
    sclk  = 1'b0;
    idle(3);
    check("mid_rst_shadow", chd0, 64'h0);
    check("mid_rst_busy", busy0, 1'b0);
    reset = 1'b0;
    idle(3);
    send_frame({32'h03000001, 32'h03000002, 32'h03000003, 32'h03000004}, 128, 1, 2,
               1'b0, 1'b0, 1'b0);
    idle(8);
    check("post_rst_count", q0.size(), 4);
    check("post_rst_shadow", chd0, 64'h0004_0003_0002_0001);
    check("post_rst_err", err0, 0);
    check("post_rst_sync_shadow", chd1, 64'h0004_0003_0002_0001);

    // Slow sclk with csel edges off the clkin grid.
    pulse_reset();
    clear();
    send_frame({32'h03001234, 32'h03005678, 32'h07009ABC, 32'h0300FFFF}, 128, 3, 7,
               1'b0, 1'b0, 1'b0);
    idle(12);
    check("slow_count", q0.size(), 4);
    check("slow_w3", q0[3], {2'd3, 4'h3, 16'hFFFF});
    check("slow_shadow", chd0, 64'hFFFF_0000_5678_1234);
    check("slow_sync_count", q1.size(), 4);
    check("slow_sync_w2", q1[2], {2'd2, 4'h7, 16'h9ABC});
    check("slow_sync_shadow", chd1, 64'hFFFF_0000_5678_1234);
    check("slow_err", err0 + err1, 0);

    // Three good and two bad frames.
    pulse_reset();
    clear();
    isq = 1'b1;
    send_frame(160'h300111, 24, 1, 2, 1'b0, 1'b0, 1'b0);
    idle(3);
    send_frame(160'h310222, 24, 1, 2, 1'b0, 1'b0, 1'b0);
    idle(3);
    send_frame(160'h330333, 24, 1, 2, 1'b0, 1'b0, 1'b0);
    idle(3);
    send_frame(160'h3FFFFFF, 26, 1, 2, 1'b0, 1'b0, 1'b0);
    idle(3);
    isq = 1'b0;
    send_frame({32'h03004444, 8'h00}, 40, 1, 2, 1'b0, 1'b0, 1'b0);
    idle(8);
    check("mix_count", q0.size(), 4);
    check("mix_err", err0, 2);
    check("mix_sync_err", err1, 2);
    check("mix_shadow", chd0, 64'h0333_0000_0222_4444);
`ifdef DAC_MON_COUNTERS_EN
    check("cnt_frames", fc0, 16'd3);
    check("cnt_errors", ec0, 16'd2);
    check("cnt_sync_frames", fc1, 16'd3);
    check("cnt_sync_errors", ec1, 16'd2);
`endif
    check("valid_err_overlap", overlap, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
